// File: rtl/multi_cycle_controller.sv
// Multi-cycle MIPS-style control FSM: Moore control outputs per state, opcode latched in
// DECODE, and a bounded wait on mem_ready in FETCH, MEMRD and MEMWR.
module multi_cycle_controller #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OPcode,
    input  logic       mem_ready,
    output logic [3:0] state,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic [1:0] PCSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       RegWrite,
    output logic       RegDest,
    output logic       MemtoReg,
    output logic       illegal_op,
    output logic       mem_timeout
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StAddiEx = 4'd9,
        StAddiWb = 4'd10,
        StJump   = 4'd11
    } state_e;

    localparam logic [5:0] OpLw   = 6'b100011;
    localparam logic [5:0] OpSw   = 6'b101011;
    localparam logic [5:0] OpRtyp = 6'b000000;
    localparam logic [5:0] OpBeq  = 6'b000100;
    localparam logic [5:0] OpAddi = 6'b001000;
    localparam logic [5:0] OpJ    = 6'b000010;

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic [7:0] cnt_q, cnt_d;
    logic       wait_st;
    logic       timeout_hit;
    logic       decode_legal;

    // A wait state times out only when memory is still busy on the last allowed cycle.
    always_comb begin
        wait_st     = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
        timeout_hit = wait_st && !mem_ready && !reset && (cnt_q == TimeoutLast);
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        cnt_d        = 8'd0;
        decode_legal = 1'b1;

        case (state_q)
            StFetch: begin
                if (mem_ready) begin
                    state_d = StDecode;
                end else if (timeout_hit) begin
                    state_d = StFetch;
                end
            end
            StDecode: begin
                op_d = OPcode;
                case (OPcode)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtyp:     state_d = StExec;
                    OpBeq:      state_d = StBranch;
                    OpAddi:     state_d = StAddiEx;
                    OpJ:        state_d = StJump;
                    default: begin
                        state_d      = StFetch;
                        decode_legal = 1'b0;
                    end
                endcase
            end
            StMemAdr: state_d = (op_q == OpLw) ? StMemRd : StMemWr;
            StMemRd: begin
                if (mem_ready) begin
                    state_d = StMemWb;
                end else if (timeout_hit) begin
                    state_d = StFetch;
                end
            end
            StMemWb: state_d = StFetch;
            StMemWr: begin
                if (mem_ready || timeout_hit) begin
                    state_d = StFetch;
                end
            end
            StExec:   state_d = StAluWb;
            StAluWb:  state_d = StFetch;
            StBranch: state_d = StFetch;
            StAddiEx: state_d = StAddiWb;
            StAddiWb: state_d = StFetch;
            StJump:   state_d = StFetch;
            default:  state_d = StFetch;
        endcase

        // Any transition (including a timeout re-entry of FETCH) restarts the wait count.
        if (wait_st && !mem_ready && !timeout_hit) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            op_q    <= 6'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state = state_q;

    // While reset is held the outputs look like FETCH with the load strobes gated off.
    always_comb begin
        IorD        = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        Branch      = 1'b0;
        PCSrc       = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        RegWrite    = 1'b0;
        RegDest     = 1'b0;
        MemtoReg    = 1'b0;
        illegal_op  = 1'b0;
        mem_timeout = 1'b0;

        if (reset) begin
            ALUSrcB = 2'b01;
        end else begin
            case (state_q)
                StFetch: begin
                    ALUSrcB     = 2'b01;
                    IRWrite     = mem_ready && !timeout_hit;
                    PCWrite     = mem_ready && !timeout_hit;
                    mem_timeout = timeout_hit;
                end
                StDecode: begin
                    ALUSrcB    = 2'b11;
                    illegal_op = !decode_legal;
                end
                StMemAdr: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                StMemRd: begin
                    IorD        = 1'b1;
                    mem_timeout = timeout_hit;
                end
                StMemWb: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                StMemWr: begin
                    IorD        = 1'b1;
                    MemWrite    = !timeout_hit;
                    mem_timeout = timeout_hit;
                end
                StExec: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                StAluWb: begin
                    RegWrite = 1'b1;
                    RegDest  = 1'b1;
                end
                StBranch: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b01;
                    Branch  = 1'b1;
                    PCSrc   = 2'b01;
                end
                StAddiEx: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                StAddiWb: RegWrite = 1'b1;
                StJump: begin
                    PCWrite = 1'b1;
                    PCSrc   = 2'b10;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed bench for multi_cycle_controller: per-cycle expected state/output vectors are
// queued as each step is driven and popped for comparison mid-cycle.
module tb_multi_cycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OPcode;
    logic       mem_ready;
    logic [3:0] state;
    logic       IorD, MemWrite, IRWrite, PCWrite, Branch;
    logic [1:0] PCSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp;
    logic       RegWrite, RegDest, MemtoReg, illegal_op, mem_timeout;

    int total = 0;
    int bad   = 0;
    logic [20:0] sb[$];

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010, ILL = 6'b111111;

    multi_cycle_controller #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .OPcode     (OPcode),
        .mem_ready  (mem_ready),
        .state      (state),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .Branch     (Branch),
        .PCSrc      (PCSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .RegWrite   (RegWrite),
        .RegDest    (RegDest),
        .MemtoReg   (MemtoReg),
        .illegal_op (illegal_op),
        .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    // Expected outputs straight from the per-state control table.
    function automatic logic [20:0] model(input logic [3:0] es, input logic mr, input logic r,
                                          input logic ei, input logic et);
        logic iord, mw, irw, pcw, br, asa, rw, rd, m2r;
        logic [1:0] pcs, asb, aop;
        logic [3:0] s;
        iord = 0; mw = 0; irw = 0; pcw = 0; br = 0; asa = 0; rw = 0; rd = 0; m2r = 0;
        pcs = 0; asb = 0; aop = 0;
        s = r ? 4'd0 : es;
        case (s)
            4'd0:  begin asb = 2'b01; irw = mr & ~r & ~et; pcw = mr & ~r & ~et; end
            4'd1:  asb = 2'b11;
            4'd2:  begin asa = 1; asb = 2'b10; end
            4'd3:  iord = 1;
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin iord = 1; mw = ~et; end
            4'd6:  begin asa = 1; aop = 2'b10; end
            4'd7:  begin rw = 1; rd = 1; end
            4'd8:  begin asa = 1; aop = 2'b01; br = 1; pcs = 2'b01; end
            4'd9:  begin asa = 1; asb = 2'b10; end
            4'd10: rw = 1;
            4'd11: begin pcw = 1; pcs = 2'b10; end
            default: ;
        endcase
        return {es, iord, mw, irw, pcw, br, pcs, asa, asb, aop, rw, rd, m2r, ei, et};
    endfunction

    task automatic step(input logic r, input logic [5:0] op, input logic mr, input logic [3:0] es,
                        input logic ei, input logic et, input string tag);
        logic [20:0] got, exp;
        @(negedge clk);
        reset = r; OPcode = op; mem_ready = mr;
        sb.push_back(model(es, mr, r, ei, et));
        #1;
        got = {state, IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc, ALUSrcA, ALUSrcB, ALUOp,
               RegWrite, RegDest, MemtoReg, illegal_op, mem_timeout};
        exp = sb.pop_front();
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    initial begin
        reset = 1'b1; OPcode = 6'd0; mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        step(1, ILL, 1, 0, 0, 0, "reset_hold");

        // lw; opcode changed after DECODE must not alter the path
        step(0, LW, 0, 0, 0, 0, "lw_fetch_wait");
        step(0, LW, 1, 0, 0, 0, "lw_fetch");
        step(0, LW, 1, 1, 0, 0, "lw_decode");
        step(0, RT, 1, 2, 0, 0, "lw_memadr");
        step(0, RT, 1, 3, 0, 0, "lw_memrd");
        step(0, RT, 1, 4, 0, 0, "lw_memwb");

        // R-type
        step(0, RT, 1, 0, 0, 0, "r_fetch");
        step(0, RT, 1, 1, 0, 0, "r_decode");
        step(0, RT, 1, 6, 0, 0, "r_exec");
        step(0, RT, 1, 7, 0, 0, "r_aluwb");

        // beq then j
        step(0, BEQ, 1, 0, 0, 0, "beq_fetch");
        step(0, BEQ, 1, 1, 0, 0, "beq_decode");
        step(0, BEQ, 1, 8, 0, 0, "beq_branch");
        step(0, JMP, 1, 0, 0, 0, "j_fetch");
        step(0, JMP, 1, 1, 0, 0, "j_decode");
        step(0, JMP, 1, 11, 0, 0, "j_jump");

        // addi
        step(0, ADDI, 1, 0, 0, 0, "addi_fetch");
        step(0, ADDI, 1, 1, 0, 0, "addi_decode");
        step(0, ADDI, 1, 9, 0, 0, "addi_ex");
        step(0, ADDI, 1, 10, 0, 0, "addi_wb");

        // illegal opcode
        step(0, ILL, 1, 0, 0, 0, "ill_fetch");
        step(0, ILL, 1, 1, 1, 0, "ill_decode");
        step(0, ILL, 1, 0, 0, 0, "ill_back_fetch");

        // sw with memory never ready: 15 write cycles, then timeout
        step(0, SW, 1, 1, 0, 0, "sw_decode");
        step(0, SW, 0, 2, 0, 0, "sw_memadr");
        for (int i = 0; i < 15; i++) step(0, SW, 0, 5, 0, 0, "sw_wait");
        step(0, SW, 0, 5, 0, 1, "sw_timeout");
        step(0, SW, 1, 0, 0, 0, "sw_to_fetch");

        // sw where mem_ready arrives exactly in the timeout cycle
        step(0, SW, 1, 1, 0, 0, "tie_decode");
        step(0, SW, 0, 2, 0, 0, "tie_memadr");
        for (int i = 0; i < 15; i++) step(0, SW, 0, 5, 0, 0, "tie_wait");
        step(0, SW, 1, 5, 0, 0, "tie_ready_wins");
        step(0, LW, 1, 0, 0, 0, "tie_fetch");

        // reset during a MEMRD wait, then FETCH timeout from a cleared counter
        step(0, LW, 1, 1, 0, 0, "rst_decode");
        step(0, LW, 0, 2, 0, 0, "rst_memadr");
        for (int i = 0; i < 3; i++) step(0, LW, 0, 3, 0, 0, "rst_memrd_wait");
        step(1, LW, 0, 3, 0, 0, "rst_mid");
        step(0, LW, 0, 0, 0, 0, "rst_after");
        for (int i = 0; i < 14; i++) step(0, LW, 0, 0, 0, 0, "fetch_wait");
        step(0, LW, 0, 0, 0, 1, "fetch_timeout");
        step(0, LW, 0, 0, 0, 0, "fetch_restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
